// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a one-word holding buffer so back-to-back
// words stream with no gap cycle; en freezes serial progress but not acceptance.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hb_q, hb_d;
    logic             hb_full_q, hb_full_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             accept;
    logic             load;

    // Acceptance needs an empty buffer and a transfer needs a full one, so the
    // two can never coincide on one edge.
    assign accept = din_valid && !hb_full_q;

    always_comb begin
        state_d   = state_q;
        hb_d      = hb_q;
        hb_full_d = hb_full_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        load      = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (hb_full_q) begin
                        load    = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        if (hb_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            sr_d    = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (MSB_FIRST) begin
                            sr_d = {sr_q[WIDTH-2:0], 1'b0};
                        end else begin
                            sr_d = {1'b0, sr_q[WIDTH-1:1]};
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (load) begin
            sr_d      = hb_q;
            cnt_d     = '0;
            hb_full_d = 1'b0;
        end

        if (accept) begin
            hb_d      = din;
            hb_full_d = 1'b1;
        end

        // Output bit is registered from the next-state shifter contents.
        if (state_d == SHIFT) begin
            sout_d = MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0];
        end else begin
            sout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= IDLE;
            hb_q      <= '0;
            hb_full_q <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            sout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hb_q      <= hb_d;
            hb_full_q <= hb_full_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            sout_q    <= sout_d;
        end
    end

    assign din_ready   = clr_n && !hb_full_q;
    assign sout        = sout_q;
    assign sout_valid  = (state_q == SHIFT);
    assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
    assign busy        = (state_q == SHIFT) || hb_full_q;

endmodule
